// File: rtl/aes128_enc_iter.sv
// aes128_enc_iter: iterative AES-128 encryption core.
// It runs one round per clock over a shared round datapath and expands the key on the fly.
// The input and output sides each use a valid/ready handshake. Input and output never overlap.
// Optional feature: define AES_KEYOUT_EN to register the round-10 key on `keyout`.
// When the macro is undefined, `keyout` is tied to zero.
module aes128_enc_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
    output logic [127:0] keyout
);

    // Forward S-box. Byte b sits at bits [{~b, 3'b111} -: 8], so entry 0 is at the top.
    localparam logic [2047:0] SboxRom = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {StIdle, StBusy, StDone} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [127:0] ct_q, ct_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;

    logic [7:0]   rcon;
    logic [127:0] nk;
    logic [127:0] sr_out;
    logic [127:0] round_out;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxRom[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows. Byte index is row + 4*column.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // One step of the AES-128 key schedule: four words out of four words in.
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Round constant for the round currently in flight
    always_comb begin
        rcon = 8'h00;
        unique case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Shared round datapath. The final round skips MixColumns.
    always_comb begin
        nk        = key_expand(key_q, rcon);
        sr_out    = sub_shift(st_q);
        round_out = (rnd_q == 4'd10) ? (sr_out ^ nk) : (mix_columns(sr_out) ^ nk);
    end

`ifdef AES_KEYOUT_EN
    logic [127:0] ko_q, ko_d;
`endif

    // Next-state logic for the FSM and the datapath registers
    always_comb begin
        fsm_d       = fsm_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        key_d       = key_q;
        ct_d        = ct_q;
`ifdef AES_KEYOUT_EN
        ko_d        = ko_q;
`endif
        unique case (fsm_q)
            StIdle: begin
                // in_ready_q gates the accept, so the cycle right after reset stays closed
                if (in_ready_q && in_valid) begin
                    st_d  = plaintext ^ key;
                    key_d = key;
                    rnd_d = 4'd1;
                    fsm_d = StBusy;
                end
            end
            StBusy: begin
                st_d  = round_out;
                key_d = nk;
                if (rnd_q == 4'd10) begin
                    ct_d  = round_out;
`ifdef AES_KEYOUT_EN
                    ko_d  = nk;
`endif
                    fsm_d = StDone;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    rnd_d = 4'd0;
                    fsm_d = StIdle;
                end
            end
            default: begin
                rnd_d = 4'd0;
                fsm_d = StIdle;
            end
        endcase
        // Handshake flags are registered copies of the next state
        in_ready_d  = (fsm_d == StIdle);
        out_valid_d = (fsm_d == StDone);
    end

    // State register and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= StIdle;
            rnd_q       <= 4'd0;
            st_q        <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef AES_KEYOUT_EN
    // Round-10 key register that gives the decryption side its starting key
    always_ff @(posedge clk) begin
        if (rst) begin
            ko_q <= '0;
        end else begin
            ko_q <= ko_d;
        end
    end

    assign keyout = ko_q;
`else
    assign keyout = 128'h0;
`endif

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign cipher_text = ct_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Scoreboard testbench for aes128_enc_iter. It uses the FIPS-197 vectors.
// Stimulus pushes the expected results, and a negedge monitor checks each handoff.
module tb_aes128_enc_iter;

    localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_KEYOUT_EN
    localparam logic [127:0] KoB  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KoC  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`else
    localparam logic [127:0] KoB  = 128'h0;
    localparam logic [127:0] KoC  = 128'h0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] cipher_text;
    logic [127:0] keyout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_hand   = 0;

    logic [255:0] exp_q[$];

    // Monitor bookkeeping
    logic         ov_prev        = 1'b0;
    logic         lat_valid      = 1'b0;
    logic         prev_acc_valid = 1'b0;
    logic         b2b_chk        = 1'b0;
    int           prev_acc       = 0;
    logic [127:0] held_ct, held_ko;
    logic [255:0] e;

    aes128_enc_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plaintext   (plaintext),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .cipher_text (cipher_text),
        .keyout      (keyout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check128(input string name, input logic [127:0] act,
                                     input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: accept timing, latency, backpressure stability and the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            lat_valid      = 1'b0;
            prev_acc_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (b2b_chk && prev_acc_valid) check_int("accept_spacing", cyc + 1 - prev_acc, 12);
                prev_acc       = cyc + 1;
                prev_acc_valid = 1'b1;
                lat_valid      = 1'b1;
            end
            if (out_valid && !ov_prev) begin
                if (lat_valid) check_int("latency", cyc - prev_acc, 10);
                held_ct = cipher_text;
                held_ko = keyout;
            end
            if (out_valid) check_int("in_ready_while_out_valid", int'(in_ready), 0);
            if (out_valid && !out_ready) begin
                check128("ct_stable", cipher_text, held_ct);
                check128("keyout_stable", keyout, held_ko);
            end
            if (out_valid && out_ready) begin
                n_hand++;
                if (exp_q.size() == 0) begin
                    check_int("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check128("cipher_text", cipher_text, e[255:128]);
                    check128("keyout", keyout, e[127:0]);
                end
            end
        end
        ov_prev = out_valid;
    end

    // All stimulus tasks run in the posedge+1 phase
    task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] ko);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            check_int("send_ready_timeout", 0, 1);
        end else begin
            plaintext = pt;
            key       = k;
            in_valid  = 1'b1;
            exp_q.push_back({ct, ko});
            @(posedge clk); #1;
            in_valid  = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check_int("drain", exp_q.size(), 0);
    endtask

    initial begin
        int  t;
        int  h0;
        logic rdy;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        plaintext = '0;
        key       = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_int("rst_in_ready", int'(in_ready), 0);
        check_int("rst_out_valid", int'(out_valid), 0);
        check128("rst_cipher_text", cipher_text, 128'h0);
        check128("rst_keyout", keyout, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_int("in_ready_after_rst", int'(in_ready), 1);

        // App B with latency check
        send(PtB, KeyB, CtB, KoB);
        wait_done();

        // Backpressure: hold out_ready low and wiggle the inputs
        out_ready = 1'b0;
        send(PtB, KeyB, CtB, KoB);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check_int("bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            in_valid  = ~in_valid;
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        h0        = n_hand;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_int("bp_one_handoff", n_hand, h0 + 1);
        check_int("bp_out_valid_cleared", int'(out_valid), 0);
        wait_done();

        // Back-to-back: App B then App C.1 with in_valid held high
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        plaintext = PtB;
        key       = KeyB;
        in_valid  = 1'b1;
        exp_q.push_back({CtB, KoB});
        @(posedge clk); #1;
        b2b_chk   = 1'b1;
        plaintext = PtC;
        key       = KeyC;
        exp_q.push_back({CtC, KoC});
        t = 0;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!rdy && t < 40);
        check_int("b2b_second_accept", int'(rdy), 1);
        in_valid = 1'b0;
        b2b_chk  = 1'b0;
        wait_done();

        // Reset in round 5 of App B, then reissue App B
        send(PtB, KeyB, CtB, KoB);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check_int("midrst_out_valid", int'(out_valid), 0);
        check_int("midrst_in_ready", int'(in_ready), 0);
        check128("midrst_cipher_text", cipher_text, 128'h0);
        check128("midrst_keyout", keyout, 128'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_int("midrst_in_ready_after", int'(in_ready), 1);
        check_int("midrst_out_valid_after", int'(out_valid), 0);
        send(PtB, KeyB, CtB, KoB);
        wait_done();

        // in_valid pulsed during BUSY with different data must be ignored
        send(PtC, KeyC, CtC, KoC);
        repeat (2) @(posedge clk);
        #1;
        plaintext = PtB;
        key       = KeyB;
        in_valid  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done();
        repeat (20) @(posedge clk);
        #1;
        check_int("total_handoffs", n_hand, 6);
        check_int("idle_out_valid", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
